// File: rtl/pc_update_unit.sv
// Program-counter update stage with a hardware return-address stack.
// Build option PC_UPDATE_RAS_WRAP_EN: a call on a full stack overwrites the oldest entry instead of dropping.
module pc_update_unit #(
  parameter int          PC_WIDTH  = 5,
  parameter int          RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             branch,
  input  logic                             cond,
  input  logic                             call,
  input  logic                             ret,
  input  logic [PC_WIDTH-1:0]              target,
  output logic [PC_WIDTH-1:0]              pc,
  output logic [PC_WIDTH-1:0]              pc_next,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_empty,
  output logic                             ras_full,
  output logic                             err
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
`ifdef PC_UPDATE_RAS_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       ptr_inc;
  logic [PW-1:0]       ptr_dec;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ret_op;
  logic                call_op;
  logic                do_pop;
  logic                do_push;
  logic                err_set;

  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));

  // wr_ptr always names the next free slot; with a full circular stack it is also the oldest entry
  always_comb begin
    pc_inc  = pc + PC_WIDTH'(1);
    ptr_inc = (wr_ptr == PW'(RAS_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    ptr_dec = (wr_ptr == '0) ? PW'(RAS_DEPTH - 1) : wr_ptr - PW'(1);
    ras_top = ras_mem[ptr_dec];
    ret_op  = !stall && ret;
    call_op = !stall && call && !ret;
    do_pop  = ret_op && !ras_empty;
    do_push = call_op && (!ras_full || WRAP);
    err_set = (ret_op && (ras_empty || call)) || (call_op && ras_full && !WRAP);
  end

  always_comb begin
    pc_next = pc_inc;
    if (reset)                 pc_next = PC_WIDTH'(RESET_PC);
    else if (stall)            pc_next = pc;
    else if (ret)              pc_next = do_pop ? ras_top : pc_inc;
    else if (call)             pc_next = target;
    else if (branch && cond)   pc_next = target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= PC_WIDTH'(RESET_PC);
      ras_count <= '0;
      wr_ptr    <= '0;
      err       <= 1'b0;
    end else begin
      pc  <= pc_next;
      err <= err | err_set;
      if (do_push) begin
        wr_ptr <= ptr_inc;
        if (!ras_full) ras_count <= ras_count + CW'(1);
      end else if (do_pop) begin
        wr_ptr    <= ptr_dec;
        ras_count <= ras_count - CW'(1);
      end
    end
  end

  // Stack contents are don't-care after reset, so no reset term here
  always_ff @(posedge clk) begin
    if (!reset && do_push) ras_mem[wr_ptr] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_update_unit.sv
// Bench for pc_update_unit: directed scenarios plus random control traffic
// checked every cycle against a queue-based model of the PC and return stack.
module tb_pc_update_unit;

  localparam int W     = 5;
  localparam int DEPTH = 4;
  localparam int RPC   = 0;
`ifdef PC_UPDATE_RAS_WRAP_EN
  localparam bit M_WRAP = 1'b1;
`else
  localparam bit M_WRAP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, stall, branch, cond, call, ret;
  logic [W-1:0] target;
  logic [W-1:0] pc, pc_next;
  logic [2:0]   ras_count;
  logic         ras_empty, ras_full, err;

  int total = 0;
  int bad   = 0;

  int m_pc;
  int m_q[$];
  bit m_err;

  pc_update_unit #(.PC_WIDTH(W), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .cond(cond),
    .call(call), .ret(ret), .target(target), .pc(pc), .pc_next(pc_next),
    .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit rs, input bit st, input bit br, input bit cd,
                     input bit cl, input bit rt, input int tg);
    int nq[$];
    int nxt;
    int inc;
    bit nerr;
    reset = rs; stall = st; branch = br; cond = cd; call = cl; ret = rt;
    target = W'(tg);
    nq   = m_q;
    nerr = m_err;
    inc  = (m_pc + 1) % (1 << W);
    if (rs) begin
      nxt = RPC;
      nq.delete();
      nerr = 1'b0;
    end else if (st) begin
      nxt = m_pc;
    end else if (rt) begin
      if (nq.size() > 0) nxt = nq.pop_back();
      else begin
        nxt  = inc;
        nerr = 1'b1;
      end
      if (cl) nerr = 1'b1;
    end else if (cl) begin
      nxt = tg;
      if (nq.size() < DEPTH) nq.push_back(inc);
      else if (M_WRAP) begin
        void'(nq.pop_front());
        nq.push_back(inc);
      end else nerr = 1'b1;
    end else if (br && cd) begin
      nxt = tg;
    end else begin
      nxt = inc;
    end
    #1;
    chk("pc_next", 32'(pc_next), 32'(nxt));
    @(posedge clk);
    m_pc = nxt; m_q = nq; m_err = nerr;
    #1;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("ras_count", 32'(ras_count), 32'(m_q.size()));
    chk("ras_empty", 32'(ras_empty), 32'(m_q.size() == 0));
    chk("ras_full", 32'(ras_full), 32'(m_q.size() == DEPTH));
    chk("err", 32'(err), 32'(m_err));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_to(input int n);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(n);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch = 1'b0; cond = 1'b0;
    call = 1'b0; ret = 1'b0; target = '0;
    m_pc = RPC; m_err = 1'b0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("reset_pc", 32'(pc), 32'(RPC));
    idle(40);

    rst_to(3);
    cyc(0, 0, 1, 0, 0, 0, 20);
    chk("branch_not_taken", 32'(pc), 32'd4);
    cyc(0, 0, 1, 1, 0, 0, 20);
    chk("branch_taken", 32'(pc), 32'd20);

    rst_to(5);
    cyc(0, 0, 0, 0, 1, 0, 12);
    idle(2);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("ret_simple", 32'(pc), 32'd6);

    rst_to(2);
    cyc(0, 0, 0, 0, 1, 0, 10);
    idle(1);
    cyc(0, 0, 1, 1, 1, 0, 20);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("ret_nested1", 32'(pc), 32'd12);
    cyc(0, 0, 1, 1, 0, 1, 9);
    chk("ret_nested2", 32'(pc), 32'd3);

    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1, 0, 17);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("underflow_err", 32'(err), 32'd1);
    idle(3);
    chk("err_sticky", 32'(err), 32'd1);

    rst_to(0);
    cyc(0, 0, 0, 0, 1, 0, 10);
    cyc(0, 0, 0, 0, 1, 0, 11);
    cyc(0, 0, 0, 0, 1, 0, 12);
    cyc(0, 0, 0, 0, 1, 0, 13);
    cyc(0, 0, 0, 0, 1, 0, 14);
    chk("overflow_full", 32'(ras_full), 32'd1);
    chk("overflow_err", 32'(err), M_WRAP ? 32'd0 : 32'd1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("ovf_ret1", 32'(pc), M_WRAP ? 32'd14 : 32'd13);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("ovf_ret4", 32'(pc), M_WRAP ? 32'd11 : 32'd1);

    rst_to(6);
    cyc(0, 0, 0, 0, 1, 0, 25);
    cyc(0, 0, 0, 0, 1, 1, 30);
    chk("callret_pc", 32'(pc), 32'd7);
    chk("callret_err", 32'(err), 32'd1);
    cyc(0, 0, 0, 0, 1, 0, 9);
    cyc(1, 0, 0, 0, 1, 0, 9);
    chk("reset_with_call", 32'(ras_count), 32'd0);

    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0,
          1'($urandom), 1'($urandom),
          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
          int'($urandom_range(0, (1 << W) - 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_update_unit.md
# pc_update_unit

Parametrised program-counter update stage for the pipelined CPU fetch path. It holds the PC register and selects the next PC from sequential increment, conditional branch target, or call target. It also keeps a hardware return-address stack (RAS) so that `ret` redirects without a target supplied by the datapath. It replaces the fixed 5-bit two-input PC select by adding configurable width, stack depth, a stall hold and error reporting.

## Interface
Parameters:
- `PC_WIDTH`, 5, width of PC, target and stack entries
- `RAS_DEPTH`, 4, number of return-address entries (≥2)
- `RESET_PC`, 0, PC value loaded on reset

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  1  hold PC and stack this cycle
- `branch`  in  1  current instruction is a conditional branch
- `cond`  in  1  branch condition result; only meaningful with `branch`
- `call`  in  1  current instruction is a call (unconditional)
- `ret`  in  1  current instruction is a return
- `target`  in  PC_WIDTH  branch/call destination
- `pc`  out  PC_WIDTH  registered current PC
- `pc_next`  out  PC_WIDTH  combinational value `pc` takes on the next edge
- `ras_count`  out  $clog2(RAS_DEPTH+1)  valid stack entries
- `ras_empty`  out  1  `ras_count == 0`
- `ras_full`  out  1  `ras_count == RAS_DEPTH`
- `err`  out  1  sticky error flag (underflow, overflow drop, call+ret conflict)

## Operation
- Sequential increment: `pc+1` modulo 2^PC_WIDTH (all-ones wraps to 0).
- Next-PC priority, highest first:
  - `stall`: `pc_next = pc`; no push, pop or error update.
  - `ret`: pop top of stack and load it into the PC. If the stack is empty, load `pc+1`, leave the stack unchanged and set `err`.
  - `call`: push `pc+1` and load `target`.
  - `branch & cond`: load `target`.
  - Otherwise: load `pc+1`.
- `ret & call` in the same cycle: `ret` is executed, `call` is ignored, and `err` is set.
- `branch` together with `call` or `ret`: the `call`/`ret` path wins and `branch` is ignored. This does not set `err`.
- Call while full: behaviour depends on `RAS_WRAP_EN` (see Configuration). The PC is always redirected to `target`.
- Stack is LIFO. The entry popped is always the most recently pushed surviving entry.
- `err` stays set once raised. Only `reset` clears it.

## Timing
- Reset values: `pc = RESET_PC`, `ras_count = 0`, `ras_empty = 1`, `ras_full = 0`, `err = 0`. Stack contents are don't-care.
- `pc_next` is valid in the same cycle as its inputs. `pc` takes that value on the next rising edge, so redirect latency is 1 cycle.
- Push and pop take effect on the same edge as the PC update. `ras_count`, `ras_empty` and `ras_full` reflect the new state the cycle after.
- `err` rises on the edge that commits the offending operation.
- Reset in the same cycle as any control input: reset wins and the other inputs are ignored.
- Reset mid-sequence, for example while the stack holds entries: the stack empties immediately and the old entries are never returned.
- A `ret` in the cycle immediately after a `call` returns that call's `pc+1`. No bypass bubble is needed because the stack is updated on the call edge.

## Configuration
- Macro `PC_UPDATE_RAS_WRAP_EN`.
- Defined: the stack is circular. A call while full overwrites the oldest entry and pushes the new one. `ras_count` stays at `RAS_DEPTH`. `err` is not set.
- Undefined: a call while full does not push, so the return address is dropped. `ras_count` is unchanged and `err` is set.
- All other behaviour is identical in both builds.

## Test plan
- Reset then 40 idle cycles, `PC_WIDTH=5`: `pc` counts 0,1,…,31,0,1,… and wraps correctly; `err=0`.
- At `pc=3`, `branch=1 cond=0 target=20`: next `pc=4`. At `pc=4`, `branch=1 cond=1 target=20`: next `pc=20`.
- At `pc=5`, `call target=12`: `pc=12`, `ras_count=1`. Idle 2 cycles, then `ret`: `pc=6`, `ras_empty=1`. Nested calls at pc 2→10 and 11→20, then two `ret`: `pc` goes to 12, then 3.
- `stall=1` held 3 cycles with `call` asserted: `pc` and `ras_count` unchanged. `ret` on an empty stack: `pc` increments and `err=1`, which stays 1 until `reset`.
- `RAS_DEPTH=4`, five nested calls from pcs 0,10,11,12,13: with macro defined, `ras_full=1` and `err=0`, and four `ret` return 14,13,12,11. Without the macro, `err=1` and four `ret` return 13,12,11,1.
- `call` and `ret` in the same cycle with one entry (7) stacked: `pc=7`, `ras_count=0`, `err=1`. Asserting `reset` together with `call`: `pc=RESET_PC`, `ras_count=0`.
